// File: rtl/fcam_pkg.sv
// Shared FractCAM definitions: slice grid geometry and the per-slice / per-group
// priority results exchanged between the AND stage and the match encoder.
package fcam_pkg;

    localparam int SLICE_W      = 4;
    localparam int GROUP_SLICES = 4;

    typedef struct packed {
        logic       any;
        logic       multi;
        logic [1:0] loc;
    } slice_res_t;

    typedef struct packed {
        logic       any;
        logic       multi;
        logic [3:0] idx;
    } group_res_t;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res++;
            v = v >>> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-way priority reduction: lowest set input wins, multi flags two or
// more set inputs or any already-multi input from the level below.
module prio_enc4
    import fcam_pkg::*;
(
    input  logic [SLICE_W-1:0] any_i,
    input  logic [SLICE_W-1:0] multi_i,
    output logic               any_o,
    output logic               multi_o,
    output logic [1:0]         loc_o
);

    logic two_plus;

    always_comb begin
        // NOTE: every output gets a default before the priority chain, so no latch is inferred.
        loc_o    = 2'd0;
        two_plus = (any_i[0] & any_i[1]) | (any_i[0] & any_i[2]) | (any_i[0] & any_i[3]) |
                   (any_i[1] & any_i[2]) | (any_i[1] & any_i[3]) | (any_i[2] & any_i[3]);
        any_o    = |any_i;
        multi_o  = (|multi_i) | two_plus;
        if (any_i[0])      loc_o = 2'd0;
        else if (any_i[1]) loc_o = 2'd1;
        else if (any_i[2]) loc_o = 2'd2;
        else if (any_i[3]) loc_o = 2'd3;
    end

endmodule

// File: rtl/match_prio_enc.sv
// Three-stage pipelined lowest-index priority encoder for the FractCAM match vector,
// with valid/ready handshakes and a pass-through lookup tag.
module match_prio_enc
    import fcam_pkg::*;
#(
    parameter  int D     = 64,
    parameter  int TAG_W = 8,
    localparam int IDX_W = clog2(D)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [D-1:0]     s_match,
    input  logic [TAG_W-1:0] s_tag,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_hit,
    output logic             m_multi,
    output logic [IDX_W-1:0] m_idx,
    output logic [TAG_W-1:0] m_tag
);

    localparam int NS     = D / SLICE_W;
    localparam int NG     = NS / GROUP_SLICES;
    localparam int NG_PAD = 16;

    logic en;

    slice_res_t [NS-1:0] s1_res_w, s1_res_d, s1_res_q;
    logic                s1_valid_d, s1_valid_q;
    logic [TAG_W-1:0]    s1_tag_d, s1_tag_q;

    group_res_t [NG-1:0] s2_grp_w, s2_grp_d, s2_grp_q;
    logic                s2_valid_d, s2_valid_q;
    logic [TAG_W-1:0]    s2_tag_d, s2_tag_q;

    logic                m_valid_d, m_valid_q;
    logic                m_hit_d, m_hit_q;
    logic                m_multi_d, m_multi_q;
    logic [IDX_W-1:0]    m_idx_d, m_idx_q;
    logic [TAG_W-1:0]    m_tag_d, m_tag_q;

    // S1: one encoder per 4-bit slice of the incoming vector.
    for (genvar k = 0; k < NS; k++) begin : g_s1
        logic       any, multi;
        logic [1:0] loc;
        prio_enc4 u_enc (
            .any_i   (s_match[k*SLICE_W +: SLICE_W]),
            .multi_i ('0),
            .any_o   (any),
            .multi_o (multi),
            .loc_o   (loc)
        );
        assign s1_res_w[k] = '{any: any, multi: multi, loc: loc};
    end

    logic [NS-1:0] s1_any, s1_multi;

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            s1_any[k]   = s1_res_q[k].any;
            s1_multi[k] = s1_res_q[k].multi;
        end
    end

    // S2: per 16-bit group, pick the first hit slice and append its in-slice location.
    for (genvar g = 0; g < NG; g++) begin : g_s2
        logic       any, multi;
        logic [1:0] sel;
        prio_enc4 u_enc (
            .any_i   (s1_any[g*GROUP_SLICES +: GROUP_SLICES]),
            .multi_i (s1_multi[g*GROUP_SLICES +: GROUP_SLICES]),
            .any_o   (any),
            .multi_o (multi),
            .loc_o   (sel)
        );
        assign s2_grp_w[g] = '{any: any, multi: multi,
                               idx: {sel, s1_res_q[g*GROUP_SLICES + int'(sel)].loc}};
    end

    // S3: groups are padded to 16 so a fixed two-level 4-way tree covers every legal D.
    logic [NG_PAD-1:0]      pad_any, pad_multi;
    logic [NG_PAD-1:0][3:0] pad_idx;

    always_comb begin
        pad_any   = '0;
        pad_multi = '0;
        pad_idx   = '0;
        for (int g = 0; g < NG; g++) begin
            pad_any[g]   = s2_grp_q[g].any;
            pad_multi[g] = s2_grp_q[g].multi;
            pad_idx[g]   = s2_grp_q[g].idx;
        end
    end

    logic [3:0]      l3a_any, l3a_multi;
    logic [3:0][1:0] l3a_loc;

    for (genvar h = 0; h < 4; h++) begin : g_s3
        prio_enc4 u_enc (
            .any_i   (pad_any[h*4 +: 4]),
            .multi_i (pad_multi[h*4 +: 4]),
            .any_o   (l3a_any[h]),
            .multi_o (l3a_multi[h]),
            .loc_o   (l3a_loc[h])
        );
    end

    logic       top_any, top_multi;
    logic [1:0] top_loc;
    logic [7:0] idx_full;

    prio_enc4 u_s3_top (
        .any_i   (l3a_any),
        .multi_i (l3a_multi),
        .any_o   (top_any),
        .multi_o (top_multi),
        .loc_o   (top_loc)
    );

    assign idx_full = {top_loc, l3a_loc[top_loc], pad_idx[{top_loc, l3a_loc[top_loc]}]};

    always_comb begin
        en         = !m_valid_q || m_ready;
        s_ready    = en;
        s1_valid_d = s1_valid_q;
        s1_res_d   = s1_res_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_grp_d   = s2_grp_q;
        s2_tag_d   = s2_tag_q;
        m_valid_d  = m_valid_q;
        m_hit_d    = m_hit_q;
        m_multi_d  = m_multi_q;
        m_idx_d    = m_idx_q;
        m_tag_d    = m_tag_q;
        if (en) begin
            s1_valid_d = s_valid;
            s1_res_d   = s1_res_w;
            s1_tag_d   = s_tag;
            s2_valid_d = s1_valid_q;
            s2_grp_d   = s2_grp_w;
            s2_tag_d   = s1_tag_q;
            m_valid_d  = s2_valid_q;
            m_hit_d    = top_any;
            m_multi_d  = top_multi;
            m_idx_d    = IDX_W'(idx_full);
            m_tag_d    = s2_tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_grp_q   <= '0;
            s2_tag_q   <= '0;
            m_valid_q  <= 1'b0;
            m_hit_q    <= 1'b0;
            m_multi_q  <= 1'b0;
            m_idx_q    <= '0;
            m_tag_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before.
            s1_valid_q <= s1_valid_d;
            s1_res_q   <= s1_res_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_grp_q   <= s2_grp_d;
            s2_tag_q   <= s2_tag_d;
            m_valid_q  <= m_valid_d;
            m_hit_q    <= m_hit_d;
            m_multi_q  <= m_multi_d;
            m_idx_q    <= m_idx_d;
            m_tag_q    <= m_tag_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_hit   = m_hit_q;
    assign m_multi = m_multi_q;
    assign m_idx   = m_idx_q;
    assign m_tag   = m_tag_q;

endmodule

// File: tb/tb_match_prio_enc.sv
// Self-checking bench for match_prio_enc: scoreboard of expected {hit,multi,idx,tag}
// filled on each input transfer and drained on each output transfer.
module tb_match_prio_enc;

    localparam int D     = 64;
    localparam int TAG_W = 8;
    localparam int IDX_W = 6;

    logic             clk;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [D-1:0]     s_match;
    logic [TAG_W-1:0] s_tag;
    logic             m_valid;
    logic             m_ready;
    logic             m_hit;
    logic             m_multi;
    logic [IDX_W-1:0] m_idx;
    logic [TAG_W-1:0] m_tag;

    match_prio_enc #(.D(D), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_match (s_match),
        .s_tag   (s_tag),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_hit   (m_hit),
        .m_multi (m_multi),
        .m_idx   (m_idx),
        .m_tag   (m_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          pops   = 0;
    logic [15:0] sb[$];
    logic        stall_prev = 1'b0;
    logic [16:0] held;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: lowest set bit and popcount, independent of the slice tree.
    function automatic logic [15:0] model(input logic [63:0] v, input logic [7:0] t);
        logic [5:0] idx;
        idx = 6'd0;
        for (int i = 63; i >= 0; i--)
            if (v[i]) idx = 6'(i);
        return {(v != 64'd0), ($countones(v) >= 2), idx, t};
    endfunction

    function automatic logic [63:0] rand_vec();
        case ($urandom_range(0, 3))
            0:       return 64'd1 << $urandom_range(0, 63);
            1:       return {$urandom(), $urandom()};
            2:       return {$urandom(), $urandom()} & {$urandom(), $urandom()} &
                            {$urandom(), $urandom()} & {$urandom(), $urandom()};
            default: return 64'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("hold_stable", {m_valid, m_hit, m_multi, m_idx, m_tag}, held);
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'(sb.size()), 1);
                end else begin
                    check($sformatf("result_%0d", pops), {m_hit, m_multi, m_idx, m_tag},
                          sb.pop_front());
                    pops++;
                end
            end
            if (s_valid && s_ready)
                sb.push_back(model(s_match, s_tag));
            stall_prev = m_valid && !m_ready;
            held       = {m_valid, m_hit, m_multi, m_idx, m_tag};
        end
    end

    task automatic single_lookup(input logic [63:0] v, input logic [7:0] t, input string name);
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_match = v;
        s_tag   = t;
        #1;
        check({name, "_s_ready"}, s_ready, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        check({name, "_lat1"}, m_valid, 0);
        @(posedge clk); #1;
        check({name, "_lat2"}, m_valid, 0);
        @(posedge clk); #1;
        check({name, "_lat3"}, m_valid, 1);
    endtask

    task automatic drain(input string name);
        int n;
        n       = 0;
        m_ready = 1'b1;
        s_valid = 1'b0;
        while ((sb.size() != 0 || m_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drained"}, 64'(sb.size()), 0);
    endtask

    logic [63:0] vecs[8];

    initial begin
        int accepted;
        int pops_before;
        int sent;
        int cyc;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_match = '0;
        s_tag   = '0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_m_valid", m_valid, 0);
        check("reset_outputs", {m_hit, m_multi, m_idx, m_tag}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", m_valid, 0);

        // Directed lookups, including lowest/highest index boundaries.
        single_lookup(64'h0000_0000_0000_0100, 8'h11, "t1_bit8");
        single_lookup(64'h0000_0000_0000_0000, 8'h22, "t2_zero");
        single_lookup(64'h8000_0000_0001_0010, 8'h33, "t3_multi");
        single_lookup(64'h8000_0000_0000_0000, 8'h44, "t3_bit63");
        single_lookup(64'h0000_0000_0000_0001, 8'h55, "bit0");
        single_lookup(64'hFFFF_FFFF_FFFF_FFFF, 8'h66, "all_ones");
        single_lookup(64'h0000_0000_0000_000C, 8'h77, "same_slice_multi");
        drain("directed");

        // Back-to-back stream of 8 with downstream stalled on cycles 5..7.
        vecs = '{64'h0000_0000_0000_0002, 64'h0000_0000_0010_0000, 64'h0000_0100_0000_8000,
                 64'h4000_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_F000_0000,
                 64'h0008_0000_0000_0000, 64'h0000_0000_0000_0800};
        accepted    = 0;
        pops_before = pops;
        for (int c = 0; c < 40 && accepted < 8; c++) begin
            m_ready = !(c >= 5 && c <= 7);
            s_valid = 1'b1;
            s_match = vecs[accepted];
            s_tag   = 8'(8'h40 + accepted);
            #1;
            check($sformatf("stream_s_ready_c%0d", c), s_ready, (c < 5 || c > 7));
            @(negedge clk);
            if (s_valid && s_ready) accepted++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check("stream_accepted", accepted, 8);
        drain("stream");
        check("stream_emitted", pops - pops_before, 8);

        // Random traffic against the reference model.
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 60000) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            s_match = rand_vec();
            s_tag   = 8'($urandom());
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        check("rand_sent", sent, 10000);
        drain("random");

        // Reset with three lookups in flight.
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_match = 64'd1 << (i * 9 + 3);
            s_tag   = 8'(8'hA0 + i);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_outputs", {m_hit, m_multi, m_idx, m_tag}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("midrst_no_stale_%0d", i), m_valid, 0);
        end
        single_lookup(64'h0000_0400_0000_0000, 8'h5A, "after_reset");
        drain("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
